// File: rtl/scan_decoder_pkg.sv
// ============================================================================
// scan_decoder_pkg : shared state encoding and mode constants
// Revision: 1.0
// ============================================================================
`default_nettype none

package scan_decoder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_t;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

`default_nettype wire

// File: rtl/scan_decoder_if.sv
// ============================================================================
// scan_decoder_if : select request/ready handshake bundle
// Revision: 1.0
// ============================================================================
`default_nettype none

interface scan_decoder_if #(
  parameter int SEL_W = 3
);
  logic             sel_valid;
  logic [SEL_W-1:0] sel;
  logic             sel_ready;

  modport master (output sel_valid, output sel, input sel_ready);
  modport slave  (input sel_valid, input sel, output sel_ready);
endinterface

`default_nettype wire

// File: rtl/scan_decoder_onehot_dec.sv
// ============================================================================
// onehot_dec : combinational index to one-hot decoder
// Revision: 1.0
// ============================================================================
`default_nettype none

module onehot_dec #(
  parameter int SEL_W = 3
) (
  input  wire logic [SEL_W-1:0]      idx_i,
  output logic      [2**SEL_W-1:0]   onehot_o
);

  for (genvar i = 0; i < 2**SEL_W; i++) begin : g_bit
    assign onehot_o[i] = (idx_i == SEL_W'(i));
  end

endmodule

`default_nettype wire

// File: rtl/scan_decoder.sv
// ============================================================================
// scan_decoder : registered one-hot decoder with direct and auto-scan modes
// Optional macro SCAN_DECODER_BLANK_EN adds a break-before-make blank cycle.
// Revision: 1.0
// ============================================================================
`default_nettype none

module scan_decoder
  import scan_decoder_pkg::*;
#(
  parameter int SEL_W      = 3,
  parameter int DWELL      = 4,
  parameter int ACTIVE_LOW = 0,
  localparam int OUT_W     = 2**SEL_W
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             en_i,
  input  wire logic             mode_i,
  scan_decoder_if.slave         sel_if,
  output logic      [OUT_W-1:0] y_o,
  output logic                  y_valid_o,
  output logic      [SEL_W-1:0] scan_idx_o,
  output logic                  wrap_o
);

  localparam int                CNT_W   = $clog2(DWELL + 1);
  localparam logic [CNT_W-1:0]  C_LAST  = CNT_W'(DWELL - 1);
  localparam logic [OUT_W-1:0]  C_Y_OFF = (ACTIVE_LOW != 0) ? {OUT_W{1'b1}} : {OUT_W{1'b0}};

  state_t           state_q, state_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0] y_q, y_d, w_onehot;
  logic             valid_q, valid_d;
  logic             ready_q, ready_d;
  logic             wrap_q, wrap_d;
  logic             w_xfer;
`ifdef SCAN_DECODER_BLANK_EN
  logic             blank_q, blank_d;
  logic [SEL_W-1:0] pend_q, pend_d;
`endif

  assign w_xfer = (state_q == DIRECT) && ready_q && sel_if.sel_valid;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    wrap_d  = 1'b0;
`ifdef SCAN_DECODER_BLANK_EN
    blank_d = 1'b0;
    pend_d  = pend_q;
`endif
    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (en_i && mode_i == MODE_SCAN) begin
          state_d = SCAN;
          idx_d   = '0;
          cnt_d   = '0;
          valid_d = 1'b1;
        end else if (en_i) begin
          state_d = DIRECT;
        end
      end
      DIRECT: begin
        if (!en_i || mode_i != MODE_DIRECT) begin
          state_d = IDLE;
          valid_d = 1'b0;
`ifdef SCAN_DECODER_BLANK_EN
        end else if (blank_q) begin
          idx_d   = pend_q;
          valid_d = 1'b1;
        end else if (w_xfer && valid_q && sel_if.sel != idx_q) begin
          blank_d = 1'b1;
          pend_d  = sel_if.sel;
          valid_d = 1'b0;
`endif
        end else if (w_xfer) begin
          idx_d   = sel_if.sel;
          valid_d = 1'b1;
        end
      end
      SCAN: begin
        if (!en_i || mode_i != MODE_SCAN) begin
          state_d = IDLE;
          valid_d = 1'b0;
          cnt_d   = '0;
`ifdef SCAN_DECODER_BLANK_EN
        end else if (blank_q) begin
          idx_d   = idx_q + 1'b1;
          wrap_d  = (idx_q == {SEL_W{1'b1}});
          valid_d = 1'b1;
          cnt_d   = '0;
        end else if (cnt_q == C_LAST) begin
          blank_d = 1'b1;
          valid_d = 1'b0;
`else
        end else if (cnt_q == C_LAST) begin
          idx_d   = idx_q + 1'b1;
          wrap_d  = (idx_q == {SEL_W{1'b1}});
          cnt_d   = '0;
`endif
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
`ifdef SCAN_DECODER_BLANK_EN
    ready_d = (state_d == DIRECT) && !blank_d;
`else
    ready_d = (state_d == DIRECT);
`endif
  end

  // The pattern register always reflects the next index, so holding is free.
  onehot_dec #(.SEL_W(SEL_W)) u_dec (
    .idx_i    (idx_d),
    .onehot_o (w_onehot)
  );

  assign y_d = valid_d ? (w_onehot ^ C_Y_OFF) : C_Y_OFF;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      y_q     <= C_Y_OFF;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      wrap_q  <= wrap_d;
    end
  end

`ifdef SCAN_DECODER_BLANK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blank_q <= 1'b0;
      pend_q  <= '0;
    end else begin
      blank_q <= blank_d;
      pend_q  <= pend_d;
    end
  end
`endif

  assign sel_if.sel_ready = ready_q;
  assign y_o              = y_q;
  assign y_valid_o        = valid_q;
  assign scan_idx_o       = idx_q;
  assign wrap_o           = wrap_q;

endmodule

`default_nettype wire

// File: tb/tb_scan_decoder.sv
// ============================================================================
// tb_scan_decoder : directed bench for scan_decoder (two parameter sets)
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_scan_decoder;

`ifdef SCAN_DECODER_BLANK_EN
  localparam int C_BLANK = 1;
`else
  localparam int C_BLANK = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       en_a, mode_a, en_b, mode_b;
  logic [7:0] y_a;
  logic       yv_a, wrap_a;
  logic [2:0] idx_a;
  logic [3:0] y_b;
  logic       yv_b, wrap_b;
  logic [1:0] idx_b;
  int         total = 0;
  int         bad   = 0;

  scan_decoder_if #(.SEL_W(3)) if_a ();
  scan_decoder_if #(.SEL_W(2)) if_b ();

  scan_decoder #(.SEL_W(3), .DWELL(4), .ACTIVE_LOW(0)) u_dut_a (
    .clk(clk), .rst(rst), .en_i(en_a), .mode_i(mode_a), .sel_if(if_a),
    .y_o(y_a), .y_valid_o(yv_a), .scan_idx_o(idx_a), .wrap_o(wrap_a)
  );

  scan_decoder #(.SEL_W(2), .DWELL(1), .ACTIVE_LOW(1)) u_dut_b (
    .clk(clk), .rst(rst), .en_i(en_b), .mode_i(mode_b), .sel_if(if_b),
    .y_o(y_b), .y_valid_o(yv_b), .scan_idx_o(idx_b), .wrap_o(wrap_b)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected scan output c cycles after the first cycle showing index 0.
  function automatic void exp_scan(input int c, input int dwell, input int outw,
                                   output logic [7:0] y, output logic v,
                                   output logic w, output int idx);
    int per;
    per = dwell + C_BLANK;
    idx = (c / per) % outw;
    v   = !((C_BLANK != 0) && ((c % per) == dwell));
    y   = v ? (8'b1 << idx) : 8'h00;
    w   = (c > 0) && ((c % (per * outw)) == 0);
  endfunction

  task automatic xfer_a(input logic [2:0] s);
    if_a.sel = s;
    if_a.sel_valid = 1'b1;
    step();
    if_a.sel_valid = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    total++; if (y_a !== 8'h00)  begin bad++; $display("FAIL rst_y_a got=%h exp=00", y_a); end
    total++; if (yv_a !== 1'b0)  begin bad++; $display("FAIL rst_yv_a got=%b exp=0", yv_a); end
    total++; if (if_a.sel_ready !== 1'b0) begin bad++; $display("FAIL rst_ready_a got=%b exp=0", if_a.sel_ready); end
    total++; if (idx_a !== 3'd0) begin bad++; $display("FAIL rst_idx_a got=%0d exp=0", idx_a); end
    total++; if (wrap_a !== 1'b0) begin bad++; $display("FAIL rst_wrap_a got=%b exp=0", wrap_a); end
    total++; if (y_b !== 4'hF)   begin bad++; $display("FAIL rst_y_b got=%h exp=f", y_b); end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_direct();
    en_a = 1'b1; mode_a = 1'b0;
    step();
    total++; if (if_a.sel_ready !== 1'b1) begin bad++; $display("FAIL dir_entry_ready got=%b exp=1", if_a.sel_ready); end
    total++; if (yv_a !== 1'b0 || y_a !== 8'h00) begin bad++; $display("FAIL dir_entry_y got=%h/%b exp=00/0", y_a, yv_a); end
    xfer_a(3'd5);
    total++; if (y_a !== 8'h20 || yv_a !== 1'b1 || idx_a !== 3'd5) begin bad++; $display("FAIL dir_sel5 got=%h/%b/%0d exp=20/1/5", y_a, yv_a, idx_a); end
    repeat (3) step();
    total++; if (y_a !== 8'h20 || yv_a !== 1'b1) begin bad++; $display("FAIL dir_hold got=%h/%b exp=20/1", y_a, yv_a); end
    xfer_a(3'd5);
    total++; if (y_a !== 8'h20 || if_a.sel_ready !== 1'b1) begin bad++; $display("FAIL dir_same got=%h/%b exp=20/1", y_a, if_a.sel_ready); end
    xfer_a(3'd3);
`ifdef SCAN_DECODER_BLANK_EN
    total++; if (y_a !== 8'h00 || yv_a !== 1'b0 || if_a.sel_ready !== 1'b0) begin bad++; $display("FAIL dir_blank3 got=%h/%b/%b exp=00/0/0", y_a, yv_a, if_a.sel_ready); end
    step();
`endif
    total++; if (y_a !== 8'h08 || idx_a !== 3'd3 || if_a.sel_ready !== 1'b1) begin bad++; $display("FAIL dir_sel3 got=%h/%0d/%b exp=08/3/1", y_a, idx_a, if_a.sel_ready); end
    xfer_a(3'd7);
`ifdef SCAN_DECODER_BLANK_EN
    total++; if (y_a !== 8'h00 || if_a.sel_ready !== 1'b0) begin bad++; $display("FAIL dir_blank7 got=%h/%b exp=00/0", y_a, if_a.sel_ready); end
    step();
`endif
    total++; if (y_a !== 8'h80 || idx_a !== 3'd7) begin bad++; $display("FAIL dir_sel7 got=%h/%0d exp=80/7", y_a, idx_a); end
    if_a.sel = 3'd2;
    step();
    total++; if (y_a !== 8'h80) begin bad++; $display("FAIL dir_novalid got=%h exp=80", y_a); end
  endtask

  task automatic test_mode_switch();
    mode_a = 1'b1;
    step();
    total++; if (y_a !== 8'h00 || yv_a !== 1'b0 || if_a.sel_ready !== 1'b0) begin bad++; $display("FAIL sw_idle got=%h/%b/%b exp=00/0/0", y_a, yv_a, if_a.sel_ready); end
    step();
    total++; if (y_a !== 8'h01 || idx_a !== 3'd0 || yv_a !== 1'b1 || wrap_a !== 1'b0) begin bad++; $display("FAIL sw_scan0 got=%h/%0d/%b/%b exp=01/0/1/0", y_a, idx_a, yv_a, wrap_a); end
  endtask

  task automatic test_scan();
    logic [7:0] ey;
    logic       ev, ew;
    int         ei;
    for (int c = 1; c <= 8 * (4 + C_BLANK) + 2; c++) begin
      step();
      exp_scan(c, 4, 8, ey, ev, ew, ei);
      total++; if (y_a !== ey || yv_a !== ev) begin bad++; $display("FAIL scan_y c=%0d got=%h/%b exp=%h/%b", c, y_a, yv_a, ey, ev); end
      total++; if (wrap_a !== ew) begin bad++; $display("FAIL scan_wrap c=%0d got=%b exp=%b", c, wrap_a, ew); end
      if (ev) begin
        total++; if (idx_a !== 3'(ei)) begin bad++; $display("FAIL scan_idx c=%0d got=%0d exp=%0d", c, idx_a, ei); end
      end
    end
  endtask

  task automatic test_en_drop();
    en_a = 1'b0;
    step();
    en_a = 1'b1;
    step();
    repeat (6 * (4 + C_BLANK)) step();
    total++; if (idx_a !== 3'd6 || y_a !== 8'h40) begin bad++; $display("FAIL en_at6 got=%0d/%h exp=6/40", idx_a, y_a); end
    en_a = 1'b0;
    step();
    total++; if (y_a !== 8'h00 || yv_a !== 1'b0 || idx_a !== 3'd6) begin bad++; $display("FAIL en_off got=%h/%b/%0d exp=00/0/6", y_a, yv_a, idx_a); end
    en_a = 1'b1;
    step();
    total++; if (y_a !== 8'h01 || idx_a !== 3'd0 || yv_a !== 1'b1) begin bad++; $display("FAIL en_restart got=%h/%0d/%b exp=01/0/1", y_a, idx_a, yv_a); end
  endtask

  task automatic test_en_wins();
    en_a = 1'b0; mode_a = 1'b0;
    step();
    total++; if (yv_a !== 1'b0 || if_a.sel_ready !== 1'b0) begin bad++; $display("FAIL enwin_1 got=%b/%b exp=0/0", yv_a, if_a.sel_ready); end
    step();
    total++; if (if_a.sel_ready !== 1'b0 || y_a !== 8'h00) begin bad++; $display("FAIL enwin_2 got=%b/%h exp=0/00", if_a.sel_ready, y_a); end
  endtask

  task automatic test_active_low();
    logic [7:0] ey;
    logic       ev, ew;
    int         ei;
    en_b = 1'b1; mode_b = 1'b0;
    step();
    total++; if (if_b.sel_ready !== 1'b1 || y_b !== 4'hF) begin bad++; $display("FAIL al_entry got=%b/%h exp=1/f", if_b.sel_ready, y_b); end
    if_b.sel = 2'd2; if_b.sel_valid = 1'b1;
    step();
    if_b.sel_valid = 1'b0;
    total++; if (y_b !== 4'b1011 || yv_b !== 1'b1) begin bad++; $display("FAIL al_sel2 got=%b/%b exp=1011/1", y_b, yv_b); end
    mode_b = 1'b1;
    step();
    step();
    for (int c = 0; c <= 4 * (1 + C_BLANK) + 1; c++) begin
      if (c > 0) step();
      exp_scan(c, 1, 4, ey, ev, ew, ei);
      total++; if (y_b !== ~ey[3:0] || wrap_b !== ew) begin bad++; $display("FAIL al_scan c=%0d got=%b/%b exp=%b/%b", c, y_b, wrap_b, ~ey[3:0], ew); end
    end
    #2 rst = 1'b1;
    #1;
    total++; if (y_b !== 4'hF || yv_b !== 1'b0 || wrap_b !== 1'b0) begin bad++; $display("FAIL al_async_rst got=%b/%b/%b exp=1111/0/0", y_b, yv_b, wrap_b); end
    total++; if (idx_b !== 2'd0 || if_b.sel_ready !== 1'b0) begin bad++; $display("FAIL al_rst_idx got=%0d/%b exp=0/0", idx_b, if_b.sel_ready); end
    step();
    rst = 1'b0;
    step();
    total++; if (y_b !== 4'b1110 || idx_b !== 2'd0 || wrap_b !== 1'b0) begin bad++; $display("FAIL al_after_rst got=%b/%0d/%b exp=1110/0/0", y_b, idx_b, wrap_b); end
  endtask

  initial begin
    rst = 1'b1;
    en_a = 1'b0; mode_a = 1'b0; en_b = 1'b0; mode_b = 1'b0;
    if_a.sel_valid = 1'b0; if_a.sel = '0;
    if_b.sel_valid = 1'b0; if_b.sel = '0;
    test_reset();
    test_direct();
    test_mode_switch();
    test_scan();
    test_en_drop();
    test_en_wins();
    test_active_low();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
